// File: rtl/sawtooth_iter.sv
// rtl/sawtooth_iter.sv - iterating sawtooth-map unit on a shared, pipelined FP datapath
// One FP operation is in flight per stage; the stage counter waits out the core latency.
module sawtooth_iter #(
    parameter int PRECISION  = 32,
    parameter int EXPONENT   = 8,
    parameter int FRACTION   = 23,
    parameter int BIAS       = 127,
    parameter int OP_LATENCY = 4,
    parameter int ITER_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PRECISION-1:0] x_in,
    input  logic [PRECISION-1:0] eps_in,
    input  logic [ITER_W-1:0]    n_iter,
    output logic                 busy,
    output logic                 out_valid,
    output logic [PRECISION-1:0] out_data,
    output logic [ITER_W-1:0]    out_idx,
    output logic                 done,
    output logic                 err
);

    localparam int P     = PRECISION;
    localparam int E     = EXPONENT;
    localparam int F     = FRACTION;
    localparam int M     = FRACTION + 1;
    localparam int W     = FRACTION + 4;
    localparam int S     = OP_LATENCY + 2;
    localparam int CNT_W = $clog2(S) + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(S - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ITER_W-1:0] IDX_ONE  = ITER_W'(1);
    localparam logic [E-1:0]      EXP_ONE  = E'(BIAS);
    localparam logic [E-1:0]      EXP_HALF = E'(BIAS - 1);
    localparam logic [E-1:0]      EXP_TWO  = E'(BIAS + 1);
    localparam logic [E-1:0]      EXP_MAX  = '1;
    localparam logic [P-1:0]      FP_ONE     = {1'b0, EXP_ONE, {F{1'b0}}};
    localparam logic [P-1:0]      FP_NEG_ONE = {1'b1, EXP_ONE, {F{1'b0}}};
    localparam logic [P-1:0]      FP_HALF    = {1'b0, EXP_HALF, {F{1'b0}}};
    localparam logic [P-1:0]      FP_NEG_TWO = {1'b1, EXP_TWO, {F{1'b0}}};

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_DIV   = 4'd1;
    localparam logic [3:0] ST_ADD   = 4'd2;
    localparam logic [3:0] ST_HALF  = 4'd3;
    localparam logic [3:0] ST_FLOOR = 4'd4;
    localparam logic [3:0] ST_MUL2L = 4'd5;
    localparam logic [3:0] ST_MULE  = 4'd6;
    localparam logic [3:0] ST_SUB   = 4'd7;
    localparam logic [3:0] ST_SIGN  = 4'd8;
    localparam logic [3:0] ST_EMIT  = 4'd9;
    localparam logic [3:0] ST_FIN   = 4'd10;

    // Denormals flush to zero, results truncate, exponent overflow saturates to infinity.
    function automatic logic [P-1:0] fp_pack(input logic s, input int er, input logic [F-1:0] fr);
        if (er <= 0)
            return {s, {(P-1){1'b0}}};
        if (er >= (1 << E) - 1)
            return {s, EXP_MAX, {F{1'b0}}};
        return {s, er[E-1:0], fr};
    endfunction

    function automatic logic [P-1:0] fp_mul(input logic [P-1:0] a, input logic [P-1:0] b);
        logic             s;
        int               er;
        logic [2*M-1:0]   prod;
        logic [F-1:0]     fr;
        s = a[P-1] ^ b[P-1];
        if (a[P-2:F] == '0 || b[P-2:F] == '0)
            return {s, {(P-1){1'b0}}};
        prod = {{M{1'b0}}, 1'b1, a[F-1:0]} * {{M{1'b0}}, 1'b1, b[F-1:0]};
        er   = int'(a[P-2:F]) + int'(b[P-2:F]) - BIAS;
        if (prod[2*M-1]) begin
            er = er + 1;
            fr = prod[2*M-2 -: F];
        end else begin
            fr = prod[2*M-3 -: F];
        end
        return fp_pack(s, er, fr);
    endfunction

    function automatic logic [P-1:0] fp_div(input logic [P-1:0] a, input logic [P-1:0] b);
        logic             s;
        int               er;
        logic [2*M-1:0]   q;
        logic [F-1:0]     fr;
        s = a[P-1] ^ b[P-1];
        if (a[P-2:F] == '0)
            return {s, {(P-1){1'b0}}};
        if (b[P-2:F] == '0)
            return {s, EXP_MAX, {F{1'b0}}};
        q  = {1'b1, a[F-1:0], {M{1'b0}}} / {{M{1'b0}}, 1'b1, b[F-1:0]};
        er = int'(a[P-2:F]) - int'(b[P-2:F]) + BIAS;
        if (q[M]) begin
            fr = q[M-1:1];
        end else begin
            fr = q[M-2:0];
            er = er - 1;
        end
        return fp_pack(s, er, fr);
    endfunction

    // Mantissas carry a leading carry bit and two guard bits below the fraction.
    function automatic logic [P-1:0] fp_add(input logic [P-1:0] a, input logic [P-1:0] b);
        logic [P-1:0] big;
        logic [P-1:0] sml;
        logic [W-1:0] mb;
        logic [W-1:0] ms;
        logic [W-1:0] r;
        int           sh;
        int           p;
        int           er;
        logic [F-1:0] fr;
        if (a[P-2:F] == '0)
            return b;
        if (b[P-2:F] == '0)
            return a;
        if (a[P-2:0] >= b[P-2:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        sh = int'(big[P-2:F]) - int'(sml[P-2:F]);
        mb = {2'b01, big[F-1:0], 2'b00};
        ms = {2'b01, sml[F-1:0], 2'b00};
        ms = (sh >= W) ? '0 : (ms >> sh);
        er = int'(big[P-2:F]);
        if (big[P-1] == sml[P-1]) begin
            r = mb + ms;
            if (r[W-1]) begin
                er = er + 1;
                fr = r[W-2 -: F];
            end else begin
                fr = r[W-3 -: F];
            end
        end else begin
            r = mb - ms;
            if (r == '0)
                return '0;
            p = 0;
            for (int i = 0; i < W; i++)
                if (r[i])
                    p = i;
            r  = r << (W - 2 - p);
            er = er - (W - 2 - p);
            fr = r[W-3 -: F];
        end
        return fp_pack(big[P-1], er, fr);
    endfunction

    function automatic logic [P-1:0] fp_floor(input logic [P-1:0] h);
        int           e;
        int           nf;
        logic [F:0]   one_sh;
        logic [F:0]   low;
        logic [F-1:0] lowmask;
        logic [M:0]   mm;
        logic [F-1:0] fr;
        e = int'(h[P-2:F]);
        if (e < BIAS)
            return (!h[P-1] || e == 0) ? '0 : FP_NEG_ONE;
        if (e >= BIAS + F)
            return h;
        nf      = F - (e - BIAS);
        one_sh  = {{F{1'b0}}, 1'b1} << nf;
        low     = one_sh - {{F{1'b0}}, 1'b1};
        lowmask = low[F-1:0];
        mm      = {2'b01, h[F-1:0] & ~lowmask};
        // Negative values with a discarded fraction step one unit toward -inf.
        if (h[P-1] && (h[F-1:0] & lowmask) != '0)
            mm = mm + {1'b0, one_sh};
        if (mm[M]) begin
            e  = e + 1;
            fr = mm[F:1];
        end else begin
            fr = mm[F-1:0];
        end
        return {h[P-1], e[E-1:0], fr};
    endfunction

    function automatic logic fp_odd(input logic [P-1:0] r);
        int e;
        int idx;
        e = int'(r[P-2:F]);
        if (e == BIAS)
            return 1'b1;
        if (e > BIAS && e <= BIAS + F) begin
            idx = F - (e - BIAS);
            return r[idx];
        end
        return 1'b0;
    endfunction

    logic [3:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [P-1:0]      r_a;
    logic [P-1:0]      r_b;
    logic [P-1:0]      r_q;
    logic [P-1:0]      r_xw;
    logic [P-1:0]      r_eps;
    logic [ITER_W-1:0] r_n;
    logic              r_odd;
    logic              r_busy;
    logic              r_out_valid;
    logic [P-1:0]      r_out_data;
    logic [ITER_W-1:0] r_out_idx;
    logic              r_done;
    logic              r_err;
    logic [P-1:0]      r_pipe [OP_LATENCY];

    logic [P-1:0]      w_fp_res;
    logic [P-1:0]      w_core;
    logic [P-1:0]      w_floor;
    logic              w_last;

    always_comb begin
        w_fp_res = '0;
        case (r_op)
            OP_ADD:  w_fp_res = fp_add(r_a, r_b);
            OP_MUL:  w_fp_res = fp_mul(r_a, r_b);
            OP_DIV:  w_fp_res = fp_div(r_a, r_b);
            default: w_fp_res = '0;
        endcase
    end

    assign w_core  = r_pipe[OP_LATENCY-1];
    assign w_floor = fp_floor(r_q);
    assign w_last  = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OP_LATENCY; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_fp_res;
            for (int i = 1; i < OP_LATENCY; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_xw        <= '0;
            r_eps       <= '0;
            r_n         <= '0;
            r_odd       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_xw      <= x_in;
                        r_eps     <= eps_in;
                        r_n       <= n_iter;
                        r_a       <= x_in;
                        r_b       <= eps_in;
                        r_op      <= OP_DIV;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_out_idx <= '0;
                        r_cnt     <= '0;
                        r_state   <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (r_cnt == '0 && r_eps[P-2:F] == '0) begin
                        r_err      <= 1'b1;
                        r_out_data <= '0;
                        r_done     <= 1'b1;
                        r_state    <= ST_FIN;
                    end else if (r_cnt == '0 && r_n == '0) begin
                        r_out_data <= r_xw;
                        r_done     <= 1'b1;
                        r_state    <= ST_FIN;
                    end else if (w_last) begin
                        r_q     <= w_core;
                        r_a     <= w_core;
                        r_b     <= FP_ONE;
                        r_op    <= OP_ADD;
                        r_cnt   <= '0;
                        r_state <= ST_ADD;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_ADD: begin
                    if (w_last) begin
                        r_q     <= w_core;
                        r_a     <= w_core;
                        r_b     <= FP_HALF;
                        r_op    <= OP_MUL;
                        r_cnt   <= '0;
                        r_state <= ST_HALF;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HALF: begin
                    if (w_last) begin
                        r_q     <= w_core;
                        r_cnt   <= '0;
                        r_state <= ST_FLOOR;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_FLOOR: begin
                    r_q     <= w_floor;
                    r_odd   <= fp_odd(w_floor);
                    r_a     <= w_floor;
                    r_b     <= FP_NEG_TWO;
                    r_op    <= OP_MUL;
                    r_cnt   <= '0;
                    r_state <= ST_MUL2L;
                end
                ST_MUL2L: begin
                    if (w_last) begin
                        r_q     <= w_core;
                        r_a     <= w_core;
                        r_b     <= r_eps;
                        r_op    <= OP_MUL;
                        r_cnt   <= '0;
                        r_state <= ST_MULE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_MULE: begin
                    if (w_last) begin
                        r_q     <= w_core;
                        r_a     <= r_xw;
                        r_b     <= w_core;
                        r_op    <= OP_ADD;
                        r_cnt   <= '0;
                        r_state <= ST_SUB;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_SUB: begin
                    if (w_last) begin
                        r_q     <= w_core;
                        r_a     <= w_core;
                        r_b     <= r_odd ? FP_NEG_ONE : FP_ONE;
                        r_op    <= OP_MUL;
                        r_cnt   <= '0;
                        r_state <= ST_SIGN;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_SIGN: begin
                    // Output registers load here so out_valid and out_data line up in EMIT.
                    if (w_last) begin
                        r_q         <= w_core;
                        r_xw        <= w_core;
                        r_out_data  <= w_core;
                        r_out_idx   <= r_out_idx + IDX_ONE;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_EMIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_EMIT: begin
                    r_cnt <= '0;
                    if (r_out_idx < r_n) begin
                        r_a     <= r_xw;
                        r_b     <= r_eps;
                        r_op    <= OP_DIV;
                        r_state <= ST_DIV;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_sawtooth_iter.sv
// tb/tb_sawtooth_iter.sv - scoreboard bench for sawtooth_iter
module tb_sawtooth_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x_in;
    logic [31:0] eps_in;
    logic [7:0]  n_iter;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic        done;
    logic        err;

    sawtooth_iter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .eps_in    (eps_in),
        .n_iter    (n_iter),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0       = 0;
    int last_v   = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    logic prev_done = 1'b0;
    logic [31:0] q_data [$];
    logic [7:0]  q_idx  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [31:0] exp_d;
        logic [7:0]  exp_i;
        if (prev_done)
            check("busy_fall", busy, 0);
        prev_done = done;
        if (out_valid) begin
            valid_cnt++;
            check("valid_queued", q_data.size() != 0, 1);
            if (q_data.size() != 0) begin
                exp_d = q_data.pop_front();
                exp_i = q_idx.pop_front();
                check("data", out_data, exp_d);
                check("idx", out_idx, exp_i);
                if (exp_i == 8'd1)
                    check("first_latency", cyc - c0, 43);
                else
                    check("strobe_gap", cyc - last_v, 44);
            end
            last_v = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", busy, 1);
        end
    end

    task automatic run_job(input logic [31:0] x, input logic [31:0] e, input logic [7:0] n,
                           input logic [31:0] exp_d, input int n_valid, input logic exp_err,
                           input logic poke);
        int d0;
        int v0;
        for (int k = 1; k <= n_valid; k++) begin
            q_data.push_back(exp_d);
            q_idx.push_back(8'(k));
        end
        @(negedge clk);
        x_in   = x;
        eps_in = e;
        n_iter = n;
        start  = 1'b1;
        d0 = done_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        c0 = cyc;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        if (poke) begin
            x_in   = 32'h3F800000;
            eps_in = 32'h3F800000;
            n_iter = 8'd7;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 50 * n_valid + 20; i++) begin
            @(posedge clk);
            if (done_cnt != d0)
                break;
        end
        @(negedge clk);
        #1;
        check("done_seen", done_cnt - d0, 1);
        if (n_valid > 0)
            check("done_gap", done_cyc - last_v, 1);
        else
            check("done_latency", done_cyc - c0, 1);
        check("valid_count", valid_cnt - v0, n_valid);
        check("queue_drained", q_data.size(), 0);
        check("final_data", out_data, exp_d);
        check("err", err, exp_err);
        if (poke) begin
            repeat (60) @(posedge clk);
            #1;
            check("no_second_done", done_cnt - d0, 1);
            check("idle_after_poke", busy, 0);
        end
    endtask

    initial begin
        int d0;
        reset  = 1'b1;
        start  = 1'b0;
        x_in   = '0;
        eps_in = '0;
        n_iter = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        reset = 1'b0;

        run_job(32'h3F000000, 32'h3F800000, 8'd1, 32'h3F000000, 1, 1'b0, 1'b0);
        run_job(32'h3FC00000, 32'h3F800000, 8'd1, 32'h3F000000, 1, 1'b0, 1'b0);
        run_job(32'hBFC00000, 32'h3F800000, 8'd1, 32'hBF000000, 1, 1'b0, 1'b0);
        run_job(32'h40400000, 32'h3F800000, 8'd3, 32'hBF800000, 3, 1'b0, 1'b0);
        run_job(32'h3F400000, 32'h3F000000, 8'd2, 32'h3E800000, 2, 1'b0, 1'b0);
        run_job(32'h3F000000, 32'h00000000, 8'd5, 32'h00000000, 0, 1'b1, 1'b0);
        run_job(32'h3F000000, 32'h3F800000, 8'd1, 32'h3F000000, 1, 1'b0, 1'b0);
        run_job(32'h40490FDB, 32'h3F800000, 8'd0, 32'h40490FDB, 0, 1'b0, 1'b1);

        @(negedge clk);
        x_in   = 32'h3F000000;
        eps_in = 32'h3F800000;
        n_iter = 8'd4;
        start  = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_data", out_data, 0);
        check("abort_idx", out_idx, 0);
        q_data.delete();
        q_idx.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);

        run_job(32'h3FC00000, 32'h3F800000, 8'd1, 32'h3F000000, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
